// File: rtl/spram_access_ctrl.sv
// Stream-to-RAM controller for a 64x8 single-port RAM: write/read bursts with address auto-increment
// and a 2-entry read response buffer. Optional CLEAR sweep via `define SPRAM_ACCESS_CTRL_CLEAR_EN.
module spram_access_ctrl #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 6,
  parameter int unsigned LW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef SPRAM_ACCESS_CTRL_CLEAR_EN
  input  logic          clr_req,
`endif
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [LW-1:0] req_len,
  input  logic          wdata_valid,
  output logic          wdata_ready,
  input  logic [DW-1:0] wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          busy,
  output logic [DW-1:0] ram_data,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q
);

`ifdef SPRAM_ACCESS_CTRL_CLEAR_EN
  typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StClear} state_e;
`else
  typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain} state_e;
`endif

  state_e        state_q;
  logic [AW-1:0] cur_addr_q;
  logic [LW-1:0] beats_left_q;
  logic          inflight_q;
  logic          init_q;

  logic [DW-1:0] fifo_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    count_q;

  logic fifo_empty;
  logic idle_ok;
  logic clr_block;
  logic clear_active;
  logic wr_fire;
  logic issue;
  logic push;
  logic pop;

`ifdef SPRAM_ACCESS_CTRL_CLEAR_EN
  assign clr_block    = clr_req;
  assign clear_active = (state_q == StClear);
`else
  assign clr_block    = 1'b0;
  assign clear_active = 1'b0;
`endif

  assign fifo_empty  = (count_q == 2'd0);
  // init_q keeps req_ready low until the first clock edge after reset release.
  assign idle_ok     = (state_q == StIdle) && fifo_empty && init_q;
  assign req_ready   = idle_ok && !clr_block;
  assign wdata_ready = (state_q == StWrite);
  assign wr_fire     = wdata_ready && wdata_valid;
  // Never let buffered plus in-flight beats exceed the FIFO depth.
  assign issue       = (state_q == StRead) &&
                       (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2);
  assign push        = inflight_q;
  assign pop         = rsp_valid && rsp_ready;

  assign rsp_valid = !fifo_empty;
  assign rsp_data  = fifo_q[rd_ptr_q];
  assign busy      = (state_q != StIdle) || !fifo_empty;
  assign ram_addr  = cur_addr_q;
  assign ram_data  = wr_fire ? wdata : '0;
  assign ram_we    = wr_fire || clear_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      inflight_q   <= 1'b0;
      init_q       <= 1'b0;
    end else begin
      init_q     <= 1'b1;
      inflight_q <= issue;
      unique case (state_q)
        StIdle: begin
`ifdef SPRAM_ACCESS_CTRL_CLEAR_EN
          if (idle_ok && clr_req) begin
            state_q    <= StClear;
            cur_addr_q <= '0;
          end else
`endif
          if (req_valid && req_ready) begin
            cur_addr_q   <= req_addr;
            beats_left_q <= req_len;
            state_q      <= req_write ? StWrite : StRead;
          end
        end
        StWrite: begin
          if (wr_fire) begin
            cur_addr_q   <= cur_addr_q + 1'b1;
            beats_left_q <= beats_left_q - 1'b1;
            if (beats_left_q == '0) state_q <= StIdle;
          end
        end
        StRead: begin
          if (issue) begin
            cur_addr_q   <= cur_addr_q + 1'b1;
            beats_left_q <= beats_left_q - 1'b1;
            if (beats_left_q == '0) state_q <= StDrain;
          end
        end
        StDrain: begin
          // The last beat lands this cycle; any buffered data is still covered by busy.
          if (inflight_q) state_q <= StIdle;
        end
`ifdef SPRAM_ACCESS_CTRL_CLEAR_EN
        StClear: begin
          cur_addr_q <= cur_addr_q + 1'b1;
          if (cur_addr_q == '1) state_q <= StIdle;
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= ram_q;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_spram_access_ctrl.sv
// Self-checking bench for spram_access_ctrl with a behavioural 64x8 RAM and a response scoreboard.
module tb_spram_access_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid, req_ready, req_write;
  logic [5:0] req_addr, req_len;
  logic       wdata_valid, wdata_ready;
  logic [7:0] wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       busy;
  logic [7:0] ram_data;
  logic [5:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_q;
`ifdef SPRAM_ACCESS_CTRL_CLEAR_EN
  logic       clr_req;
`endif

  logic [7:0] ram_mem [64];
  logic [7:0] ref_mem [64];
  logic [7:0] exp_q [$];
  logic [5:0] exp_wa [$];
  logic [7:0] exp_wd [$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_data;
    ram_q <= ram_mem[ram_addr];
  end

  spram_access_ctrl #(.DW(8), .AW(6), .LW(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef SPRAM_ACCESS_CTRL_CLEAR_EN
    .clr_req     (clr_req),
`endif
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .busy        (busy),
    .ram_data    (ram_data),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_q       (ram_q)
  );

  task automatic send_cmd(input logic wr, input logic [5:0] addr, input logic [5:0] len);
    bit ok;
    ok = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (req_ready === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cmd_accept: req_ready=%b after 50 cycles, required 1", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [5:0] addr, input logic [5:0] len,
                             input logic [7:0] base, input bit gaps);
    int sent, pushed, cyc, nbeats;
    logic [5:0] a;
    logic [7:0] d;
    sent = 0; pushed = 0; cyc = 0; nbeats = int'(len) + 1;
    send_cmd(1'b1, addr, len);
    while (sent < nbeats && cyc < 200) begin
      @(negedge clk);
      wdata_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      wdata = base + 8'(sent);
      if (wdata_valid && pushed == sent) begin
        exp_wa.push_back(addr + 6'(sent));
        exp_wd.push_back(base + 8'(sent));
        pushed++;
      end
      #1;
      if (wdata_valid && wdata_ready === 1'b1) begin
        a = exp_wa.pop_front();
        d = exp_wd.pop_front();
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== a || ram_data !== d) begin
          errors++;
          $display("FAIL write_beat: we=%b addr=%0d data=%h, required we=1 addr=%0d data=%h",
                   ram_we, ram_addr, ram_data, a, d);
        end
        ref_mem[a] = d;
        sent++;
      end else begin
        checks++;
        if (ram_we !== 1'b0) begin
          errors++;
          $display("FAIL write_gap_we: ram_we=%b, required 0", ram_we);
        end
        if (gaps) begin
          checks++;
          if (wdata_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_hold: wdata_ready=%b, required 1", wdata_ready);
          end
        end
      end
      cyc++;
    end
    checks++;
    if (sent != nbeats) begin
      errors++;
      $display("FAIL write_timeout: beats=%0d, required %0d", sent, nbeats);
    end
    @(negedge clk);
    wdata_valid = 1'b0;
    #1;
    checks++;
    if (wdata_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL write_done: wdata_ready=%b busy=%b, required 0 0", wdata_ready, busy);
    end
  endtask

  task automatic read_burst(input logic [5:0] addr, input logic [5:0] len, input int stall);
    int got, cyc, nbeats;
    logic [7:0] e;
    got = 0; cyc = 0; nbeats = int'(len) + 1;
    send_cmd(1'b0, addr, len);
    for (int i = 0; i < nbeats; i++) exp_q.push_back(ref_mem[addr + 6'(i)]);
    while (got < nbeats && cyc < 400) begin
      @(negedge clk);
      rsp_ready = (cyc >= stall);
      #1;
      checks++;
      if (ram_we !== 1'b0) begin
        errors++;
        $display("FAIL read_we: ram_we=%b, required 0", ram_we);
      end
      if (stall > 0 && cyc == stall - 1) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_q[0] || ram_addr !== addr + 6'd2) begin
          errors++;
          $display("FAIL backpressure: valid=%b data=%h addr=%0d, required 1 %h %0d",
                   rsp_valid, rsp_data, ram_addr, exp_q[0], addr + 6'd2);
        end
      end
      if (rsp_valid === 1'b1 && rsp_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (rsp_data !== e) begin
          errors++;
          $display("FAIL read_beat%0d: rsp_data=%h, required %h", got, rsp_data, e);
        end
        got++;
      end
      cyc++;
    end
    checks++;
    if (got != nbeats) begin
      errors++;
      $display("FAIL read_timeout: beats=%0d, required %0d", got, nbeats);
      exp_q.delete();
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL read_done: rsp_valid=%b busy=%b, required 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || wdata_ready !== 1'b0 || ram_we !== 1'b0 || busy !== 1'b0 ||
        req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rv=%b wr=%b we=%b busy=%b rr=%b, required all 0",
               rsp_valid, wdata_ready, ram_we, busy, req_ready);
    end
    checks++;
    if (ram_addr !== 6'd0 || ram_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_ram: addr=%0d data=%h, required 0 00", ram_addr, ram_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%b, required 1", req_ready);
    end
  endtask

  task automatic test_write_read();
    write_burst(6'd5, 6'd2, 8'hA1, 1'b0);
    read_burst(6'd5, 6'd2, 0);
  endtask

  task automatic test_wrap();
    write_burst(6'd62, 6'd3, 8'd10, 1'b0);
    read_burst(6'd62, 6'd3, 0);
  endtask

  task automatic test_back_pressure();
    write_burst(6'd30, 6'd7, 8'h40, 1'b0);
    read_burst(6'd30, 6'd7, 10);
  endtask

  task automatic test_write_gaps();
    write_burst(6'd40, 6'd3, 8'h70, 1'b1);
    read_burst(6'd40, 6'd3, 0);
  endtask

  task automatic test_reset_mid_read();
    rsp_ready = 1'b0;
    send_cmd(1'b0, 6'd20, 6'd4);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midread_pre: rsp_valid=%b busy=%b, required 1 1", rsp_valid, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL midread_reset: rsp_valid=%b busy=%b we=%b, required 0 0 0",
               rsp_valid, busy, ram_we);
    end
    @(negedge clk);
    rst_n = 1'b1;
    read_burst(6'd5, 6'd2, 0);
  endtask

`ifdef SPRAM_ACCESS_CTRL_CLEAR_EN
  task automatic test_clear();
    @(negedge clk);
    clr_req = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 6'd0; req_len = 6'd0;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_prio: req_ready=%b, required 0", req_ready);
    end
    @(posedge clk);
    #1 clr_req = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== 6'(i) || ram_data !== 8'd0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL clear_%0d: we=%b addr=%0d data=%h busy=%b, required 1 %0d 00 1",
                 i, ram_we, ram_addr, ram_data, busy, i);
      end
      ref_mem[i] = 8'd0;
    end
    @(negedge clk);
    #1;
    checks++;
    if (ram_we !== 1'b0) begin
      errors++;
      $display("FAIL clear_end: ram_we=%b, required 0", ram_we);
    end
    read_burst(6'd0, 6'd63, 0);
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram_mem[i] = 8'd0;
      ref_mem[i] = 8'd0;
    end
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wdata_valid = 1'b0; wdata = '0; rsp_ready = 1'b0;
`ifdef SPRAM_ACCESS_CTRL_CLEAR_EN
    clr_req = 1'b0;
`endif
    test_reset();
    test_write_read();
    test_wrap();
    test_back_pressure();
    test_write_gaps();
    test_reset_mid_read();
`ifdef SPRAM_ACCESS_CTRL_CLEAR_EN
    test_clear();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spram_access_ctrl.md
Name: spram_access_ctrl

Overview:
- Request-side controller that sits directly upstream of the 64x8 single-port RAM and owns its data, addr and we pins.
- Converts command, write-data and read-response valid/ready streams into RAM cycles.
- Supports bursts with address auto-increment, tracks the RAM's 1-cycle read latency, and buffers read data so a stalled consumer never loses a beat.

Parameters:
DW, 8, data width; matches the RAM word.
AW, 6, address width; RAM depth is 2**AW.
LW, 6, burst length field width; a burst is req_len+1 beats.

Ports:
clk  in  1  clock; all logic on posedge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  command valid.
req_ready  out  1  command accepted when req_valid && req_ready.
req_write  in  1  1 = write burst, 0 = read burst.
req_addr  in  AW  start address.
req_len  in  LW  beats minus one.
wdata_valid  in  1  write beat valid.
wdata_ready  out  1  write beat consumed.
wdata  in  DW  write beat data.
rsp_valid  out  1  read beat valid.
rsp_ready  in  1  consumer accepts read beat.
rsp_data  out  DW  read beat data.
busy  out  1  high whenever state != IDLE or the response buffer is non-empty.
ram_data  out  DW  to RAM data.
ram_addr  out  AW  to RAM addr.
ram_we  out  1  to RAM we.
ram_q  in  DW  from RAM q.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; response buffer empty; no read in flight.
  - Outputs: rsp_valid=0, wdata_ready=0, ram_we=0, ram_addr=0, ram_data=0, busy=0, req_ready=0.
  - req_ready rises in the first cycle after rst_n deasserts.
- RAM timing contract:
  - Write commits at the posedge where ram_we=1.
  - Read: ram_addr presented with ram_we=0 at posedge N gives ram_q valid during cycle N+1.
  - ram_we is only ever high together with a consumed write beat.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - req_ready=1 only when the response buffer is empty.
  - On acceptance: load cur_addr=req_addr and beats_left=req_len, then go to WRITE or READ per req_write.
- WRITE:
  - wdata_ready=1.
  - On each wdata handshake: ram_we=1, ram_addr=cur_addr, ram_data=wdata; cur_addr increments; beats_left decrements.
  - Last beat (beats_left==0) returns to IDLE next cycle.
  - No handshake: ram_we=0 and the state holds, with no timeout.
- READ:
  - Issues one address per cycle (ram_we=0, ram_addr=cur_addr) only when occupancy + inflight < 2.
  - Occupancy is the 2-entry response FIFO count; inflight is 1 if the previous cycle issued a read.
  - The cycle after an issue, ram_q is pushed into the FIFO.
  - After the last issue, go to DRAIN.
- DRAIN:
  - Waits for the final in-flight beat to land, then returns to IDLE.
  - The FIFO may still hold data on exit. This is legal: busy stays high until the FIFO is empty.
- Response FIFO:
  - rsp_valid = FIFO non-empty; rsp_data = head entry.
  - Simultaneous push and pop allowed; a full FIFO is never pushed, guaranteed by the issue rule.
- Address arithmetic: cur_addr wraps modulo 2**AW. Start 62, len 3 gives addresses 62, 63, 0, 1.
- Maximum burst: 2**LW beats; len=63 with AW=6 covers the whole RAM.
- Reset mid-burst: aborts immediately; FIFO contents discarded; RAM contents untouched.

Optional Feature:
- Macro: SPRAM_ACCESS_CTRL_CLEAR_EN.
- Defined:
  - Adds input port clr_req (1 bit) and state CLEAR.
  - In IDLE with the FIFO empty, clr_req has priority over req_valid; req_ready=0 while clr_req is high.
  - CLEAR writes 0 to addresses 0..2**AW-1, one per cycle (ram_we=1), then returns to IDLE.
  - busy=1 throughout CLEAR; reset during CLEAR aborts it.
- Undefined: no clr_req port, no CLEAR state; the behaviour is exactly as described above.

Test Plan:
- Write burst addr=5, len=2, data A1, A2, A3 with wdata_valid held -> ram_we high 3 consecutive cycles at addr 5, 6, 7; then a read burst addr=5, len=2 returns A1, A2, A3 in order.
- Wrap-around: write addr=62, len=3, data 10..13; read addr=62, len=3 -> rsp_data 10, 11, 12, 13; ram_addr sequence 62, 63, 0, 1.
- Back-pressure: read len=7 with rsp_ready=0 for 10 cycles -> exactly 2 beats buffered, no further ram_addr issue, rsp_valid held; release -> all 8 beats delivered in order, none lost or duplicated.
- Write gaps: wdata_valid toggling 1/0 on a len=3 burst -> ram_we only on handshake cycles; FSM stays in WRITE until the 4th beat.
- Reset mid-read: assert rst_n=0 after 2 of 5 beats issued -> rsp_valid=0 and busy=0 immediately; the next command is accepted normally.
- (CLEAR_EN) clr_req pulse -> 64 consecutive ram_we cycles with ram_data=0, addresses 0..63; a subsequent read of any address returns 0.
